view_control: RTL and testbench
===============================

# view_control

Sequencing controller for the view datapath. On each `frame` tick it schedules one full screen redraw: a full background pass, then NUM_GOLD gold sprites, then NUM_STONE stone sprites, each 16×16 at a freshly loaded random position. It drives every load, enable and clear strobe of the datapath and issues a `plot` strobe aligned to the datapath's registered X/Y/colour outputs for the VGA adapter downstream.

## Interface
- NUM_GOLD, 5: gold sprites per frame (1..7)
- NUM_STONE, 3: stone sprites per frame (1..7)
- PLOT_LAT, 2: cycles from counter value to valid X_out/Y_out/Color_out
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- frame  in  1  one-cycle frame tick from the rate divider
- background_cout  in  18  background scan counter; [8:0] x, [16:9] y, bit 17 ignored
- cout  in  9  sprite pixel counter; [3:0] x, [7:4] y
- gold_cout, stone_cout  in  3 each  sprites drawn so far
- resetn_c  out  1  active-low clear of the pixel counters
- enable_c  out  1  pixel counter increment
- load_x, load_y  out  1  latch random sprite origin
- load_color, enable_x_adder, enable_y_adder  out  1  sprite pixel pipeline enables
- draw_background  out  1  background pass active
- enable_gold, enable_stone  out  1  object counter increments
- resetn_gold_stone  out  1  active-low clear of the object counters
- load_stone  out  1  colour source select: 1 = stone ROM, 0 = gold ROM
- plot  out  1  pixel write strobe to the VGA adapter
- busy  out  1  redraw in progress
- frame_done  out  1  one-cycle pulse when a redraw completes

## Operation
- Reset values: resetn_c = 0, resetn_gold_stone = 0, all other outputs 0; state IDLE; pending = 0.
- IDLE: resetn_c = 0 and resetn_gold_stone = 0. On `frame` or `pending`, go to BG and clear `pending`.
- BG: draw_background = 1. When background_cout[16:0] == 17'h1FFFF, go to LOAD_G. The counter then wraps to 0 for the next frame.
- Background plot candidate: draw_background && x < 320 && y < 240.
- LOAD_G / LOAD_S: one cycle. Asserts load_x, load_y and resetn_c = 0. load_stone = 1 in LOAD_S.
- DRAW_G / DRAW_S:
  - Asserts enable_c, load_color, enable_x_adder and enable_y_adder; every cycle is a plot candidate.
  - Exit when cout[7:0] == 255, giving exactly 256 cycles.
  - load_stone = 1 in DRAW_S.
- NEXT_G: one cycle, enable_gold = 1, resetn_c = 0.
  - If gold_cout == NUM_GOLD−1, go to LOAD_S; otherwise go to LOAD_G.
- NEXT_S: one cycle, enable_stone = 1, resetn_c = 0.
  - If stone_cout == NUM_STONE−1, go to DRAIN; otherwise go to LOAD_S.
- DRAIN: wait PLOT_LAT cycles so the last pixel is plotted, then go to DONE.
- DONE: one cycle. frame_done = 1, resetn_gold_stone = 0. Go to IDLE.
- load_stone holds its value through NEXT_S and DRAIN. This keeps the colour mux stable while the last stone pixels drain.
- busy = 1 in every state except IDLE.
- `frame` while busy sets `pending`. Further ticks while pending are dropped; at most one redraw is queued.

## Timing
- All outputs are registered (Moore), except `plot`.
- `plot` is the plot candidate delayed PLOT_LAT cycles through a shift register. It is cleared by reset.
- Each plot pulse is aligned with the pixel it writes.
- Per-sprite cost: 258 cycles (LOAD 1 + DRAW 256 + NEXT 1).
- Redraw length from `frame` to frame_done: 1 + 131072 + 258·(NUM_GOLD+NUM_STONE) + PLOT_LAT + 1 cycles.
- Defaults: 133140 cycles, well under the frame period of 8333334 cycles.
- Asynchronous reset mid-frame: go to IDLE immediately, the plot pipe clears, and the partial frame is abandoned.
- `frame` in the same cycle as DONE: sets `pending`. The next redraw starts 2 cycles later (IDLE, then BG).

## Structure
- Shared package `view_pkg`:
  - state enum
  - SPRITE_LAST = 8'd255
  - BG_LAST = 17'h1FFFF
  - SCREEN_W = 320, SCREEN_H = 240
- One sub-module, `plot_delay`: a parameterised PLOT_LAT-deep shift register with asynchronous clear.
- The FSM and the `pending` flag live in the top level.

## Test plan
- Reset held, then released with no `frame` → all outputs at reset values; busy = 0 indefinitely.
- One `frame` pulse, datapath counters modelled → draw_background high for exactly 131072 cycles; 76800 background plot pulses.
- Same run → 8 load_x pulses; 2048 sprite plot pulses; load_stone = 1 for the last 768 sprite plot pulses; frame_done once at cycle 133140.
- `frame` pulsed three times during a redraw → exactly one extra redraw; frame_done pulses twice in total.
- Reset asserted during DRAW_G of gold 2 → outputs return to reset values asynchronously; the next `frame` produces a full 133140-cycle redraw.
- NUM_GOLD = 1, NUM_STONE = 1 → redraw length 131592 cycles; enable_gold and enable_stone each pulse once.

Source files
------------

// File: rtl/view_pkg.sv
// view_pkg: shared state encoding, screen/counter limits and the Moore output decode for view_control.
//   state_t  - redraw sequencer states
//   ctl_t    - registered strobe bundle driven to the view datapath
//   decode() - strobe values for a given state
package view_pkg;
  typedef enum logic [3:0] {
    IDLE, BG, LOAD_G, DRAW_G, NEXT_G, LOAD_S, DRAW_S, NEXT_S, DRAIN, DONE
  } state_t;
  localparam logic [7:0] SPRITE_LAST = 8'd255;
  localparam logic [16:0] BG_LAST = 17'h1FFFF;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  typedef struct packed {
    logic resetn_c;
    logic enable_c;
    logic load_x;
    logic load_y;
    logic load_color;
    logic enable_x_adder;
    logic enable_y_adder;
    logic draw_background;
    logic enable_gold;
    logic enable_stone;
    logic resetn_gold_stone;
    logic load_stone;
    logic busy;
    logic frame_done;
  } ctl_t;
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    logic draw;
    draw = s inside {DRAW_G, DRAW_S};
    c = '0;
    c.resetn_c = !(s inside {IDLE, LOAD_G, LOAD_S, NEXT_G, NEXT_S});
    c.enable_c = draw;
    c.load_x = s inside {LOAD_G, LOAD_S};
    c.load_y = s inside {LOAD_G, LOAD_S};
    c.load_color = draw;
    c.enable_x_adder = draw;
    c.enable_y_adder = draw;
    c.draw_background = s == BG;
    c.enable_gold = s == NEXT_G;
    c.enable_stone = s == NEXT_S;
    c.resetn_gold_stone = !(s inside {IDLE, DONE});
    // colour mux stays on stone while the final stone pixels drain out of the pipe
    c.load_stone = s inside {LOAD_S, DRAW_S, NEXT_S, DRAIN};
    c.busy = s != IDLE;
    c.frame_done = s == DONE;
    return c;
  endfunction
endpackage

// File: rtl/plot_delay.sv
// plot_delay: DEPTH-deep shift register aligning the plot strobe with the datapath pixel pipeline.
//   clk_i, resetn_i (async active-low clear), d_i (plot candidate), q_o (delayed strobe)
module plot_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) sr_q <= '0;
    else sr_q <= (sr_q << 1) | DEPTH'(d_i);
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/view_control.sv
// view_control: per-frame redraw sequencer (background pass, gold sprites, stone sprites) for the view datapath.
//   in : clk, resetn (async active-low), frame tick, background_cout, cout, gold_cout, stone_cout
//   out: datapath counter clears/enables, sprite loads/enables, load_stone colour select,
//        plot (pipeline-aligned write strobe), busy, frame_done
module view_control
  import view_pkg::*;
#(
  parameter int NUM_GOLD  = 5,
  parameter int NUM_STONE = 3,
  parameter int PLOT_LAT  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame,
  input  logic [17:0] background_cout,
  input  logic [8:0]  cout,
  input  logic [2:0]  gold_cout,
  input  logic [2:0]  stone_cout,
  output logic        resetn_c,
  output logic        enable_c,
  output logic        load_x,
  output logic        load_y,
  output logic        load_color,
  output logic        enable_x_adder,
  output logic        enable_y_adder,
  output logic        draw_background,
  output logic        enable_gold,
  output logic        enable_stone,
  output logic        resetn_gold_stone,
  output logic        load_stone,
  output logic        plot,
  output logic        busy,
  output logic        frame_done
);
  localparam logic [2:0] GOLD_LAST = 3'(NUM_GOLD - 1);
  localparam logic [2:0] STONE_LAST = 3'(NUM_STONE - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(PLOT_LAT - 1);
  state_t state_q, state_d;
  logic pending_q, pending_d;
  logic [7:0] drain_q, drain_d;
  ctl_t ctl_q;
  logic cand;
  logic unused_bits;
  assign unused_bits = ^{background_cout[17], cout[8]};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      drain_q <= '0;
      ctl_q <= decode(IDLE);
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      drain_q <= drain_d;
      ctl_q <= decode(state_d);
    end
  end
  // a tick arriving while busy (including DONE) is remembered once; extra ticks are dropped
  always_comb begin
    state_d = state_q;
    pending_d = pending_q | frame;
    drain_d = '0;
    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        state_d = (frame || pending_q) ? BG : IDLE;
      end
      BG:     state_d = (background_cout[16:0] == BG_LAST) ? LOAD_G : BG;
      LOAD_G: state_d = DRAW_G;
      DRAW_G: state_d = (cout[7:0] == SPRITE_LAST) ? NEXT_G : DRAW_G;
      NEXT_G: state_d = (gold_cout == GOLD_LAST) ? LOAD_S : LOAD_G;
      LOAD_S: state_d = DRAW_S;
      DRAW_S: state_d = (cout[7:0] == SPRITE_LAST) ? NEXT_S : DRAW_S;
      NEXT_S: state_d = (stone_cout == STONE_LAST) ? DRAIN : LOAD_S;
      DRAIN: begin
        drain_d = drain_q + 8'd1;
        state_d = (drain_q == DRAIN_LAST) ? DONE : DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // candidate is taken against the live counter value; the datapath presents that pixel PLOT_LAT cycles later
  assign cand = (ctl_q.draw_background && background_cout[8:0] < 9'(SCREEN_W)
                 && background_cout[16:9] < 8'(SCREEN_H)) || ctl_q.load_color;
  plot_delay #(.DEPTH(PLOT_LAT)) u_plot_delay (
    .clk_i(clk),
    .resetn_i(resetn),
    .d_i(cand),
    .q_o(plot)
  );
  assign resetn_c = ctl_q.resetn_c;
  assign enable_c = ctl_q.enable_c;
  assign load_x = ctl_q.load_x;
  assign load_y = ctl_q.load_y;
  assign load_color = ctl_q.load_color;
  assign enable_x_adder = ctl_q.enable_x_adder;
  assign enable_y_adder = ctl_q.enable_y_adder;
  assign draw_background = ctl_q.draw_background;
  assign enable_gold = ctl_q.enable_gold;
  assign enable_stone = ctl_q.enable_stone;
  assign resetn_gold_stone = ctl_q.resetn_gold_stone;
  assign load_stone = ctl_q.load_stone;
  assign busy = ctl_q.busy;
  assign frame_done = ctl_q.frame_done;
endmodule

// File: tb/tb_view_control.sv
// tb_view_control: self-checking bench for view_control (5/3 and 1/1 sprite configurations) with a modelled datapath.
module tb_view_control;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic frame = 1'b0;
  int cyc = 0;
  int fcyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask
  for (genvar i = 0; i < 2; i++) begin : g
    localparam int NG = (i == 0) ? 5 : 1;
    localparam int NS = (i == 0) ? 3 : 1;
    localparam int PL = 2;
    logic resetn_c, enable_c, load_x, load_y, load_color, enable_x_adder, enable_y_adder;
    logic draw_background, enable_gold, enable_stone, resetn_gold_stone, load_stone;
    logic plot, busy, frame_done;
    logic [17:0] bgc;
    logic [8:0] cc;
    logic [2:0] gc, sc;
    logic [14:0] outs;
    logic want, wbg;
    logic [PL-1:0] hw, hb;
    int n_bgc = 0, n_bgp = 0, n_sp = 0, n_ldx = 0, n_eg = 0, n_es = 0;
    int n_done = 0, n_busy = 0, n_align = 0, last_done = 0, run = 0, last_run = 0;
    view_control #(.NUM_GOLD(NG), .NUM_STONE(NS), .PLOT_LAT(PL)) dut (
      .clk(clk), .resetn(resetn), .frame(frame), .background_cout(bgc), .cout(cc),
      .gold_cout(gc), .stone_cout(sc), .resetn_c(resetn_c), .enable_c(enable_c),
      .load_x(load_x), .load_y(load_y), .load_color(load_color),
      .enable_x_adder(enable_x_adder), .enable_y_adder(enable_y_adder),
      .draw_background(draw_background), .enable_gold(enable_gold),
      .enable_stone(enable_stone), .resetn_gold_stone(resetn_gold_stone),
      .load_stone(load_stone), .plot(plot), .busy(busy), .frame_done(frame_done)
    );
    assign outs = {resetn_c, enable_c, load_x, load_y, load_color, enable_x_adder, enable_y_adder,
                   draw_background, enable_gold, enable_stone, resetn_gold_stone, load_stone,
                   plot, busy, frame_done};
    always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        bgc <= '0;
        cc <= '0;
        gc <= '0;
        sc <= '0;
      end else begin
        bgc <= bgc + 18'(draw_background);
        cc <= !resetn_c ? 9'd0 : cc + 9'(enable_c);
        gc <= !resetn_gold_stone ? 3'd0 : gc + 3'(enable_gold);
        sc <= !resetn_gold_stone ? 3'd0 : sc + 3'(enable_stone);
      end
    end
    // a pixel is owed to the VGA adapter for every on-screen background position and every sprite pixel
    assign wbg = draw_background && bgc[8:0] < 9'd320 && bgc[16:9] < 8'd240;
    assign want = wbg || load_color;
    always @(negedge clk or negedge resetn) begin
      if (!resetn) begin
        hw <= '0;
        hb <= '0;
      end else begin
        hw <= {hw[PL-2:0], want};
        hb <= {hb[PL-2:0], wbg};
        if (plot != hw[PL-1]) n_align <= n_align + 1;
        if (plot && hb[PL-1]) n_bgp <= n_bgp + 1;
        if (plot && !hb[PL-1]) begin
          n_sp <= n_sp + 1;
          run <= load_stone ? run + 1 : 0;
        end
        n_bgc <= n_bgc + int'(draw_background);
        n_ldx <= n_ldx + int'(load_x);
        n_eg <= n_eg + int'(enable_gold);
        n_es <= n_es + int'(enable_stone);
        n_busy <= n_busy + int'(busy);
        if (frame_done) begin
          n_done <= n_done + 1;
          last_done <= cyc;
          last_run <= run;
        end
      end
    end
  end
  task automatic pulse();
    @(posedge clk);
    #1 frame = 1'b1;
    fcyc = cyc;
    @(posedge clk);
    #1 frame = 1'b0;
  endtask
  task automatic wait_done(input int b0, input int b1, output int d1);
    d1 = -1;
    for (int k = 0; k < 140000; k++) begin
      @(negedge clk);
      #1;
      if (d1 < 0 && g[1].n_done != b1) d1 = g[1].last_done;
      if (g[0].n_done != b0) break;
    end
  endtask
  initial begin
    int s_bgc, s_bgp, s_ldx, s_sp, s_eg, s_es, s_d0, s_d1, s_eg1, s_es1, s_ldx1, bz, d1, f0, found;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    check("rst_out_5x3", int'(g[0].outs), 0);
    check("rst_out_1x1", int'(g[1].outs), 0);
    bz = g[0].n_busy;
    repeat ($urandom_range(20, 60)) @(posedge clk);
    #1;
    check("idle_busy_cycles", g[0].n_busy - bz, 0);
    check("idle_out", int'(g[0].outs), 0);
    s_bgc = g[0].n_bgc; s_bgp = g[0].n_bgp; s_ldx = g[0].n_ldx; s_sp = g[0].n_sp;
    s_eg = g[0].n_eg; s_es = g[0].n_es; s_d0 = g[0].n_done; s_d1 = g[1].n_done;
    s_eg1 = g[1].n_eg; s_es1 = g[1].n_es; s_ldx1 = g[1].n_ldx;
    pulse();
    f0 = fcyc;
    repeat (3) begin
      repeat ($urandom_range(1000, 39000)) @(posedge clk);
      pulse();
    end
    wait_done(s_d0, s_d1, d1);
    check("len_5x3", g[0].last_done - f0 + 1, 133140);
    check("bg_cycles", g[0].n_bgc - s_bgc, 131072);
    check("bg_plots", g[0].n_bgp - s_bgp, 76800);
    check("load_x_pulses", g[0].n_ldx - s_ldx, 8);
    check("sprite_plots", g[0].n_sp - s_sp, 2048);
    check("gold_incs", g[0].n_eg - s_eg, 5);
    check("stone_incs", g[0].n_es - s_es, 3);
    check("stone_tail_ge768", int'(g[0].last_run >= 768), 1);
    check("len_1x1", d1 - f0 + 1, 131592);
    check("gold_incs_1x1", g[1].n_eg - s_eg1, 1);
    check("stone_incs_1x1", g[1].n_es - s_es1, 1);
    check("load_x_1x1", g[1].n_ldx - s_ldx1, 2);
    wait_done(s_d0 + 1, s_d1 + 1, d1);
    bz = g[0].n_busy;
    repeat (200) @(posedge clk);
    #1;
    check("no_third_redraw_busy", g[0].n_busy - bz, 0);
    check("done_count_5x3", g[0].n_done - s_d0, 2);
    check("done_count_1x1", g[1].n_done - s_d1, 2);
    pulse();
    found = 0;
    for (int k = 0; k < 140000; k++) begin
      @(negedge clk);
      #1;
      if (g[0].gc == 3'd2 && g[0].load_color) begin
        found = 1;
        break;
      end
    end
    check("reached_gold2", found, 1);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_5x3", int'(g[0].outs), 0);
    check("async_rst_1x1", int'(g[1].outs), 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    s_d0 = g[0].n_done; s_d1 = g[1].n_done; s_eg = g[0].n_eg; s_sp = g[0].n_sp;
    pulse();
    f0 = fcyc;
    wait_done(s_d0, s_d1, d1);
    check("len_after_rst_5x3", g[0].last_done - f0 + 1, 133140);
    check("len_after_rst_1x1", d1 - f0 + 1, 131592);
    check("gold_incs_after_rst", g[0].n_eg - s_eg, 5);
    check("sprite_plots_after_rst", g[0].n_sp - s_sp, 2048);
    check("plot_align_5x3", g[0].n_align, 0);
    check("plot_align_1x1", g[1].n_align, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
